// File: rtl/core_pkg.sv
// core_pkg: definitions shared between the fetch stage and the main control
// decoder of the multi-cycle RISC-V core.
//   fetch_state_e : fetch FSM state encoding
//   NOP_INSTR     : canonical NOP (addi x0,x0,0) used as the empty fetch word
//   OPCODE_W      : width of the instruction opcode field
//   OPC_*         : RV32I major opcodes decoded by the control unit
//   opcode_of     : extracts the opcode field from an instruction word
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FULL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          OPCODE_W  = 7;

  localparam logic [OPCODE_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_W-1:0];
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the main control decoder.
// Holds the PC, issues one instruction-memory read at a time and presents the
// fetched word to decode under a valid/ready handshake. Redirects from branch
// and jump resolution override the PC; a response belonging to a request made
// before a redirect is dropped.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imem_req / imem_addr      one-cycle read strobe and word address
//   imem_rvalid / imem_rdata  read response (one outstanding request)
//   redirect_valid / _pc      one-cycle PC override
//   out_valid / out_ready     handshake towards decode
//   out_instr / out_pc        held instruction and its PC
//   out_opcode                out_instr opcode field (combinational)
//   fetch_fault               sticky misaligned-redirect flag
module instr_fetch
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [XLEN-1:0]     out_pc,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic                fetch_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic            discard_q, discard_d;
  logic            fetch_fault_q, fetch_fault_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    imem_req_d    = 1'b0;
    imem_addr_d   = imem_addr_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    discard_d     = discard_q;
    fetch_fault_d = fetch_fault_q;

    if (redirect_valid) begin
      // Low address bits are forced to zero; a misaligned target is flagged
      // rather than fetched.
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      out_valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        fetch_fault_d = 1'b1;
      end
      case (state_q)
        ST_IDLE, ST_FULL: state_d = ST_REQ;
        // The read strobed this cycle targets the old PC; its response must
        // still be consumed before a new request can go out.
        ST_REQ: begin
          discard_d = 1'b1;
          state_d   = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = ST_REQ;
            end else begin
              out_instr_d = imem_rdata;
              out_pc_d    = pc_q;
              out_valid_d = 1'b1;
              pc_d        = pc_q + XLEN'(4);
              state_d     = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The strobe is registered, so it is raised on entry to REQ with the PC
    // that REQ will hold.
    if (state_d == ST_REQ) begin
      imem_req_d  = 1'b1;
      imem_addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= NOP_INSTR;
      out_pc_q      <= '0;
      discard_q     <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      discard_q     <= discard_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_opcode  = opcode_of(out_instr_q);
  assign fetch_fault = fetch_fault_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multi-cycle RISC-V core, sitting directly upstream of the main control decoder. It holds the PC, issues one read at a time to instruction memory, and presents the fetched word, its PC and its opcode field to decode under a valid/ready handshake. It also accepts branch/jal/jalr redirects resolved downstream and drops any stale in-flight response.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  one-cycle read strobe
- imem_addr  out  XLEN  read address, valid while imem_req=1
- imem_rvalid  in  1  read data valid; arrives ≥1 cycle after imem_req
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  one-cycle PC override from branch/jump resolution
- redirect_pc  in  XLEN  new PC target
- out_valid  out  1  instruction held for decode
- out_ready  in  1  decode accepts the held instruction
- out_instr  out  32  fetched instruction
- out_pc  out  XLEN  PC of out_instr
- out_opcode  out  7  out_instr[6:0], combinational; drives the control decoder
- fetch_fault  out  1  sticky misaligned-redirect flag

## Operation
- FSM states: IDLE, REQ, WAIT, FULL.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, out_valid=0, out_instr=32'h0000_0013 (NOP), out_pc=0, discard=0, fetch_fault=0.
- IDLE -> REQ unconditionally.
- REQ: imem_req=1 and imem_addr=pc for exactly this cycle, then -> WAIT.
- WAIT, rvalid=1, discard=0: out_instr<=rdata, out_pc<=pc, out_valid<=1, pc<=pc+4, then -> FULL.
- WAIT, rvalid=1, discard=1: drop the data, discard<=0, then -> REQ.
- FULL: out_valid, out_instr and out_pc are held stable until out_valid&&out_ready. On that handshake, out_valid<=0 and -> REQ.
- imem_rvalid outside WAIT is ignored.
- Redirect has highest priority. In every case it sets pc<=redirect_pc and out_valid<=0.
  - IDLE or FULL: -> REQ. If out_ready=1 in FULL on the same cycle, the transfer counts as completed.
  - REQ: the request issued this cycle is stale. discard<=1, then -> WAIT.
  - WAIT with rvalid=0: discard<=1, stay in WAIT.
  - WAIT with rvalid=1: drop the data, then -> REQ.
- Misaligned redirect (redirect_pc[1:0]≠0): fetch_fault<=1, held until rst. pc<={redirect_pc[XLEN-1:2],2'b00}.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- rst mid-operation: returns to reset values next edge. Instruction memory shares rst, so no response survives reset.

## Timing
- From the rst-deassert edge: cycle 1 IDLE, cycle 2 REQ, cycle 3 earliest rvalid, cycle 4 out_valid=1.
- Steady state with 1-cycle memory and out_ready=1: one instruction per 3 cycles (REQ, WAIT, FULL).
- Redirect to new imem_req: 1 cycle when no request is outstanding; otherwise after the stale response returns.
- All outputs are registered except out_opcode.

## Structure
- Shared package core_pkg holds:
  - fetch state enum
  - NOP_INSTR = 32'h0000_0013
  - OPCODE_W = 7
  - RISC-V opcode constants shared with the control decoder
- Single module; no sub-module is warranted.

## Test plan
- Reset, 1-cycle memory returning 32'h0000_0033 at addr 0, out_ready=1 → imem_req at cycle 2 with addr 0; out_valid at cycle 4 with out_instr=0x33, out_opcode=7'b0110011, out_pc=0; next request addr=4.
- out_ready=0 for 5 cycles in FULL → outputs stable, no imem_req; release → next imem_addr=pc+4.
- Redirect to 0x100 in WAIT with 3-cycle memory → returned word dropped; next imem_addr=0x100; out_valid never asserts with the stale data.
- Redirect to 0x40 in the same cycle as rvalid → data dropped; imem_req next cycle with addr 0x40.
- Redirect to 0x102 → fetch_fault=1, next imem_addr=0x100; fetch_fault stays 1 until rst.
- PC 0xFFFF_FFFC fetched → next imem_addr=0. Assert rst during WAIT → all outputs return to reset values, fetch restarts at RESET_PC.
